// File: rtl/delayed_demux1_2_pkg.sv
// rtl/delayed_demux1_2_pkg.sv - shared width and select encodings for the delayed demux
package delayed_demux1_2_pkg;

   localparam int unsigned DATA_WIDTH = 16;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/delayed_demux1_2_dest_reg.sv
// rtl/delayed_demux1_2_dest_reg.sv - one destination: data register, valid flag, overwrite detect
module dest_reg
   import delayed_demux1_2_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_we,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q,
   output logic             o_valid,
   output logic             o_ovf_hit
);

   logic [WIDTH-1:0] r_q;
   logic             r_valid;

   // A write onto unconsumed data with no same-edge consume is an overwrite.
   assign o_ovf_hit = i_we & r_valid & ~i_clr;

   // Data register loads on write; valid sets on write, clears on consume, write wins.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_q     <= '0;
         r_valid <= 1'b0;
      end else begin
         if (i_we) begin
            r_q <= i_d;
         end
         if (i_we) begin
            r_valid <= 1'b1;
         end else if (i_clr) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_q     = r_q;
   assign o_valid = r_valid;

endmodule

// File: rtl/delayed_demux1_2.sv
// rtl/delayed_demux1_2.sv - 1:2 demux writing data one cycle after its captured request
module delayed_demux1_2
   import delayed_demux1_2_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] d,
   input  logic             delayedS,
   input  logic             load,
   input  logic             clrA,
   input  logic             clrB,
   output logic [WIDTH-1:0] qa,
   output logic [WIDTH-1:0] qb,
   output logic             validA,
   output logic             validB,
   output logic             ovf
);

   logic r_pend;
   logic r_en;
   logic r_ovf;
   logic w_we_a;
   logic w_we_b;
   logic w_ovf_a;
   logic w_ovf_b;

   // Request pipeline: capture load and its select; the write happens on the next edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pend <= 1'b0;
         r_en   <= SEL_A;
      end else begin
         r_pend <= load;
         r_en   <= delayedS;
      end
   end

   assign w_we_a = r_pend & (r_en == SEL_A);
   assign w_we_b = r_pend & (r_en == SEL_B);

   dest_reg #(.WIDTH(WIDTH)) u_dest_a (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_we      (w_we_a),
      .i_clr     (clrA),
      .i_d       (d),
      .o_q       (qa),
      .o_valid   (validA),
      .o_ovf_hit (w_ovf_a)
   );

   dest_reg #(.WIDTH(WIDTH)) u_dest_b (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_we      (w_we_b),
      .i_clr     (clrB),
      .i_d       (d),
      .o_q       (qb),
      .o_valid   (validB),
      .o_ovf_hit (w_ovf_b)
   );

   // Sticky overwrite error: any overwrite on either destination latches until reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_a | w_ovf_b) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;

endmodule

// File: tb/tb_delayed_demux1_2.sv
// tb/tb_delayed_demux1_2.sv - directed self-checking bench for delayed_demux1_2
module tb_delayed_demux1_2;

   logic        CLK;
   logic        RESET;
   logic [15:0] d;
   logic        delayedS;
   logic        load;
   logic        clrA;
   logic        clrB;
   logic [15:0] qa;
   logic [15:0] qb;
   logic        validA;
   logic        validB;
   logic        ovf;

   int n_checks = 0;
   int n_errors = 0;

   delayed_demux1_2 #(.WIDTH(16)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .d        (d),
      .delayedS (delayedS),
      .load     (load),
      .clrA     (clrA),
      .clrB     (clrB),
      .qa       (qa),
      .qb       (qb),
      .validA   (validA),
      .validB   (validB),
      .ovf      (ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [15:0] eqa, input logic [15:0] eqb,
                            input logic eva, input logic evb, input logic eovf);
      check({tag, ".qa"}, {16'h0, qa}, {16'h0, eqa});
      check({tag, ".qb"}, {16'h0, qb}, {16'h0, eqb});
      check({tag, ".validA"}, {31'h0, validA}, {31'h0, eva});
      check({tag, ".validB"}, {31'h0, validB}, {31'h0, evb});
      check({tag, ".ovf"}, {31'h0, ovf}, {31'h0, eovf});
   endtask

   initial begin
      RESET = 1'b1; d = '0; delayedS = 1'b0; load = 1'b0; clrA = 1'b0; clrB = 1'b0;
      #1;
      check_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      step();
      RESET = 1'b0;

      // single write to A, data taken on the second edge
      load = 1'b1; delayedS = 1'b0; d = 16'hFFFF;
      step();
      check_all("w1_edge1", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      load = 1'b0; d = 16'h1234;
      step();
      check_all("w1_edge2", 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);
      d = 16'h5A5A;
      step();
      check_all("w1_idle", 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);

      // consume A before the back-to-back sequence
      clrA = 1'b1;
      step();
      clrA = 1'b0;
      check_all("clrA", 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);

      // three consecutive loads: A, B, A -> second A write overflows
      load = 1'b1; delayedS = 1'b0;
      step();
      delayedS = 1'b1; d = 16'hAAAA;
      step();
      check_all("b2b_1", 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0);
      delayedS = 1'b0; d = 16'hBBBB;
      step();
      check_all("b2b_2", 16'hAAAA, 16'hBBBB, 1'b1, 1'b1, 1'b0);
      load = 1'b0; d = 16'hCCCC;
      step();
      check_all("b2b_3", 16'hCCCC, 16'hBBBB, 1'b1, 1'b1, 1'b1);

      // ovf is sticky across idle cycles and consume-then-refill writes
      d = 16'h0000;
      for (int i = 0; i < 10; i++) step();
      check("sticky_idle.ovf", {31'h0, ovf}, 32'h1);
      load = 1'b1; delayedS = 1'b0;
      step();
      delayedS = 1'b1; d = 16'h1111; clrA = 1'b1;
      step();
      load = 1'b0; d = 16'h2222; clrA = 1'b0; clrB = 1'b1;
      step();
      clrB = 1'b0;
      check_all("sticky_wr", 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b1);

      // asynchronous reset clears everything mid-cycle
      #3 RESET = 1'b1;
      #1;
      check_all("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      step();
      RESET = 1'b0;

      // write with coincident clear on A: write wins, no overflow
      load = 1'b1; delayedS = 1'b0;
      step();
      load = 1'b0; d = 16'h5555;
      step();
      check_all("pre_clrw", 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b0);
      load = 1'b1; delayedS = 1'b0;
      step();
      load = 1'b0; d = 16'h0F0F; clrA = 1'b1;
      step();
      clrA = 1'b0;
      check_all("clr_and_w", 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b0);

      // clear B with nothing pending: valid drops, data stays
      load = 1'b1; delayedS = 1'b1;
      step();
      load = 1'b0; d = 16'h7777;
      step();
      check_all("wB", 16'h0F0F, 16'h7777, 1'b1, 1'b1, 1'b0);
      clrB = 1'b1;
      step();
      clrB = 1'b0;
      check_all("clrB", 16'h0F0F, 16'h7777, 1'b1, 1'b0, 1'b0);

      // reset between sampling and write edge drops the request
      load = 1'b1; delayedS = 1'b1;
      step();
      load = 1'b0; d = 16'h9999;
      #2 RESET = 1'b1;
      #1;
      check_all("rst_mid", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      #1 RESET = 1'b0;
      step();
      check_all("rst_drop1", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      step();
      check_all("rst_drop2", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      // first edge after reset release samples normally
      RESET = 1'b1;
      #2 RESET = 1'b0;
      load = 1'b1; delayedS = 1'b0; d = 16'hEEEE;
      step();
      load = 1'b0; d = 16'h4321;
      step();
      check_all("post_rst", 16'h4321, 16'h0000, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
